// File: rtl/clock_set_ctrl_pkg.sv
// Shared mode/status codes for the clock user-control, timekeeping and display blocks.
// The FSM state encoding is identical to the displayed status code.
package clock_pkg;
  localparam logic [2:0] STATUS_SHOW_TIME      = 3'd0;
  localparam logic [2:0] STATUS_SHOW_TIME_DATE = 3'd1;
  localparam logic [2:0] STATUS_SHOW_MINUTE    = 3'd2;
  localparam logic [2:0] STATUS_SHOW_HOUR      = 3'd3;
  localparam logic [2:0] STATUS_SHOW_DAY       = 3'd4;
  localparam logic [2:0] STATUS_SHOW_MONTH     = 3'd5;
  localparam logic [2:0] STATUS_SHOW_STOP      = 3'd6;

  localparam int NUM_BTN  = 3;
  localparam int BTN_MODE = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_DOWN = 2;

  typedef enum logic [2:0] {
    ST_SHOW_TIME  = STATUS_SHOW_TIME,
    ST_SET_MINUTE = STATUS_SHOW_MINUTE,
    ST_SET_HOUR   = STATUS_SHOW_HOUR,
    ST_STOP       = STATUS_SHOW_STOP
  } mode_e;

  function automatic logic is_set(mode_e s);
    return (s == ST_SET_HOUR) || (s == ST_SET_MINUTE);
  endfunction
endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and mode/adjust outputs of the clock set controller.
interface clock_set_ctrl_if;
  logic       btn_mode, btn_up, btn_down;
  logic [2:0] status;
  logic       run_flag, inc_hour, dec_hour, inc_minute, dec_minute, blink;

  modport master (output btn_mode, btn_up, btn_down,
                  input  status, run_flag, inc_hour, dec_hour, inc_minute, dec_minute, blink);
  modport slave  (input  btn_mode, btn_up, btn_down,
                  output status, run_flag, inc_hour, dec_hour, inc_minute, dec_minute, blink);
endinterface

// File: rtl/clock_set_ctrl_btn_debounce.sv
// One raw button: 2-FF synchronizer, counting debouncer and 1-cycle press pulse on rising level.
module btn_debounce #(
  parameter int DB_W            = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      // cnt counts consecutive samples that disagree with the debounced level
      if (sync[1] == level)
        cnt <= '0;
      else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Clock user-control front end: debounced buttons drive the mode FSM, run flag, adjust pulses, blink.
// Optional held-button auto-repeat is enabled by defining CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DB_W            = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BLINK_CYCLES    = 16384,
  parameter int TIMEOUT_CYCLES  = 60000,
  parameter int REPEAT_DELAY    = 20000,
  parameter int REPEAT_RATE     = 4000
) (
  input  logic             clock,
  input  logic             reset,
  clock_set_ctrl_if.slave  bus
);
  logic [NUM_BTN-1:0] raw, lvl, prs;
  assign raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  btn_debounce #(.DB_W(DB_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTN-1:0] (
    .clock(clock), .reset(reset), .raw(raw), .level(lvl), .press(prs)
  );

  mode_e           state, state_nxt;
  logic [DB_W-1:0] to_cnt, blink_cnt;
  logic            run_q, blink_q;
  logic [3:0]      pls_q, pls_nxt;   // {inc_hour, dec_hour, inc_minute, dec_minute}
  logic            rep_up, rep_dn, up_ev, dn_ev;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  logic [DB_W-1:0] rep_cnt;
  logic            rep_armed, hold_up, hold_dn, rep_fire, unused_lvl;
  assign hold_up  = lvl[BTN_UP] & ~lvl[BTN_DOWN];
  assign hold_dn  = lvl[BTN_DOWN] & ~lvl[BTN_UP];
  assign rep_fire = is_set(state) && (hold_up | hold_dn) && !(|prs) &&
                    (rep_cnt == (rep_armed ? DB_W'(REPEAT_RATE - 1) : DB_W'(REPEAT_DELAY - 1)));
  assign rep_up   = rep_fire & hold_up;
  assign rep_dn   = rep_fire & hold_dn;
  assign unused_lvl = lvl[BTN_MODE];

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else if ((|prs) || !(hold_up | hold_dn) || (state_nxt != state)) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else
      rep_cnt <= rep_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign rep_up     = 1'b0;
  assign rep_dn     = 1'b0;
  assign unused_cfg = ^{lvl, DB_W'(REPEAT_DELAY), DB_W'(REPEAT_RATE)};
`endif

  assign up_ev = prs[BTN_UP] | rep_up;
  assign dn_ev = prs[BTN_DOWN] | rep_dn;

  // Mode press outranks timeout and adjust; simultaneous up+down cancels both.
  always_comb begin
    state_nxt = state;
    pls_nxt   = 4'b0000;
    if (prs[BTN_MODE]) begin
      case (state)
        ST_SHOW_TIME:  state_nxt = ST_SET_HOUR;
        ST_SET_HOUR:   state_nxt = ST_SET_MINUTE;
        ST_SET_MINUTE: state_nxt = ST_STOP;
        default:       state_nxt = ST_SHOW_TIME;
      endcase
    end else if (is_set(state) && to_cnt == DB_W'(TIMEOUT_CYCLES))
      state_nxt = ST_SHOW_TIME;
    else if (up_ev ^ dn_ev) begin
      if (state == ST_SET_HOUR)   pls_nxt = {up_ev, dn_ev, 2'b00};
      if (state == ST_SET_MINUTE) pls_nxt = {2'b00, up_ev, dn_ev};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_SHOW_TIME;
      run_q     <= 1'b1;
      pls_q     <= 4'b0000;
      blink_q   <= 1'b0;
      blink_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state <= state_nxt;
      run_q <= (state_nxt == ST_SHOW_TIME);
      pls_q <= pls_nxt;
      if ((|prs) || rep_up || rep_dn || (state_nxt != state) || !is_set(state))
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      // an adjust pulse restarts the phase so the edited field shows its new value
      if ((state_nxt != state) || !is_set(state) || (|pls_nxt)) begin
        blink_cnt <= '0;
        blink_q   <= 1'b0;
      end else if (blink_cnt == DB_W'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else
        blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.status     = state;
  assign bus.run_flag   = run_q;
  assign bus.inc_hour   = pls_q[3];
  assign bus.dec_hour   = pls_q[2];
  assign bus.inc_minute = pls_q[1];
  assign bus.dec_minute = pls_q[0];
  assign bus.blink      = blink_q;
endmodule
